cpu_regfile: RTL
================

Name: cpu_regfile

Overview:
- Register file and hardware stack memory for the byte-bus CPU core.
- Directly downstream of the core's register and stack ports:
  - Serves two read ports (ra/rb) and one write port (rdata/rw).
  - Serves one stack port (sp/spi/spo/spw).
- After reset, a clear sequencer zeroes every register and stack word, then raises ready. Top level ANDs ready into the core's locked input.

Parameters:
- REG_AW, 8, register index width (2^REG_AW 32-bit registers).
- STK_AW, 10, stack index width (2^STK_AW 32-bit words).
- CLEAR_ON_RESET, 1, 1 = run clear sequencer after reset; 0 = ready one cycle after reset release, contents undefined.

Ports:
- clock  in  1  system clock; all state changes on rising edge except the read-address latch.
- resetn  in  1  asynchronous active-low reset.
- ra  in  REG_AW  read port A index; also write index.
- rb  in  REG_AW  read port B index.
- rav  out  32  register[ra].
- rbv  out  32  register[rb].
- rdata  in  32  write data.
- rw  in  1  write strobe; writes rdata to register[ra] at rising edge.
- sp  in  STK_AW  stack word index.
- spo  in  32  stack write data.
- spw  in  1  stack write strobe; writes spo to stack[sp] at rising edge.
- spi  out  32  stack[sp].
- ready  out  1  1 = clear complete, ports live.

Behaviour:
- Reset (resetn=0, async):
  - ready=0; clear counter=0; state=CLEAR (or DONE if CLEAR_ON_RESET=0).
  - rav, rbv and spi read 0 while ready=0.
  - Memory contents are not touched by the async reset itself.
- States: CLEAR -> DONE. No other transitions; only reset returns to CLEAR.
- CLEAR:
  - 1 word per cycle. Counter width max(REG_AW, STK_AW)+1.
  - Each cycle: write 0 to stack[cnt] when cnt < 2^STK_AW; write 0 to register[cnt] when cnt < 2^REG_AW.
  - External rw/spw are ignored while ready=0.
  - DONE is entered on the cycle after the last index (cnt = max depth - 1) is written.
  - ready rises on the same edge. Defaults: 1024 clear cycles; ready is high at rising edge 1025 after reset release.
- Read timing: read addresses are latched on the falling edge of clock. rav/rbv/spi are valid before the next rising edge, so an index driven from a register at edge N is readable at edge N+1. Implement as negedge-addressed block RAM, or as distributed RAM with an equivalent result.
- Write timing: rw=1 at rising edge N updates register[ra] at edge N. rw and spw are independent and may be set in the same cycle.
- Bypass:
  - If rw=1 and ra is the same index as a read port, that port returns rdata combinationally. This covers rav when reading the location being written, and rbv when rb==ra.
  - If spw=1, spi returns spo.
  - Purpose: the core sees the new value in the cycle the write is pending.
- Register 0 is an ordinary register (not hard-wired to zero).
- No wrap logic is needed: indices are exact-width and wrap naturally. The core handles sp arithmetic.
- Reset asserted mid-CLEAR restarts the clear from index 0.
- Reset asserted in DONE returns to CLEAR and clears again.

Test Plan:
- Release reset, hold rw=spw=0 -> ready=0 for exactly 1024 cycles, then 1. Read every register and every stack word -> all 0x00000000.
- After ready: ra=0x05, rdata=0xDEADBEEF, rw=1 for 1 cycle; next cycle rb=0x05 -> rbv=0xDEADBEEF; rav with ra=0x05 -> 0xDEADBEEF.
- Bypass: ra=rb=0x10, rw=1, rdata=0x12345678 -> rav=rbv=0x12345678 in the same cycle. sp=0x3FF, spw=1, spo=0xCAFEF00D -> spi=0xCAFEF00D in the same cycle.
- Simultaneous writes: rw=1 (ra=0xFF, rdata=1) and spw=1 (sp=0x000, spo=2) in one cycle -> register[0xFF]=1 and stack[0]=2.
- Writes ignored during clear:
  - At clear cycle 100, rw=1, ra=0x50, rdata=0xFFFFFFFF.
  - Result: register[0x50]=0 after ready; rav=0 while ready=0.
- Reset mid-clear:
  - Pulse resetn low at clear cycle 500.
  - Result: ready stays 0 for another full 1024 cycles. Stack word 0x300, pre-loaded by backdoor to 0xAAAA5555, reads 0 after ready.

Source files
------------

// File: rtl/cpu_regfile.sv
// cpu_regfile: 32-bit register file plus hardware stack memory for the byte-bus core.
// After reset a clear sequencer zeroes both memories one index per cycle.
// The ports go live when ready rises.
module cpu_regfile #(
    parameter int REG_AW         = 8,
    parameter int STK_AW         = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    output logic [31:0]       rav,
    output logic [31:0]       rbv,
    input  logic [31:0]       rdata,
    input  logic              rw,
    input  logic [STK_AW-1:0] sp,
    input  logic [31:0]       spo,
    input  logic              spw,
    output logic [31:0]       spi,
    output logic              ready
);

    localparam int MAXAW = (REG_AW > STK_AW) ? REG_AW : STK_AW;
    localparam int CW    = MAXAW + 1;
    localparam logic [CW-1:0] LAST  = CW'((2 ** MAXAW) - 1);
    localparam logic [CW-1:0] REG_N = CW'(2 ** REG_AW);
    localparam logic [CW-1:0] STK_N = CW'(2 ** STK_AW);

    typedef enum logic {CLEAR, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            clr_we;

    logic [31:0] rf  [2**REG_AW];
    logic [31:0] stk [2**STK_AW];

    logic [REG_AW-1:0] ra_q, rb_q;
    logic [STK_AW-1:0] sp_q;

    // Sequencer state, clear counter and ready flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : DONE;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ready <= (state_nx == DONE);
        end
    end

    // Next state: walk every index once, then park in DONE until reset
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            CLEAR: begin
                cnt_nx = cnt + CW'(1);
                if (cnt == LAST) state_nx = DONE;
            end
            default: ;
        endcase
    end

    // No clear writes while reset is held, so the async reset never touches memory
    assign clr_we = (state == CLEAR) && resetn;

    // Memory writes: clear has priority; external strobes only count once ready
    always_ff @(posedge clock) begin
        if (clr_we) begin
            if (cnt < STK_N) stk[cnt[STK_AW-1:0]] <= '0;
            if (cnt < REG_N) rf[cnt[REG_AW-1:0]]  <= '0;
        end else if (ready) begin
            if (rw)  rf[ra]  <= rdata;
            if (spw) stk[sp] <= spo;
        end
    end

    // Read addresses captured mid-cycle, so an index launched at edge N reads before edge N+1
    always_ff @(negedge clock) begin
        ra_q <= ra;
        rb_q <= rb;
        sp_q <= sp;
    end

    // Read muxes: zero until ready, pending write data bypassed to matching ports
    always_comb begin
        rav = '0;
        rbv = '0;
        spi = '0;
        if (ready) begin
            rav = rw               ? rdata : rf[ra_q];
            rbv = (rw && rb == ra) ? rdata : rf[rb_q];
            spi = spw              ? spo   : stk[sp_q];
        end
    end

endmodule
